// File: rtl/telemetry_pkg.sv
// Shared constants and types for the telemetry packetizer.
package telemetry_pkg;

    localparam logic [15:0] MAGIC       = 16'hA5E1;
    localparam int          N_WORDS_DEF = 24;

    // Header, sequence, N_WORDS channels, checksum.
    function automatic int pkt_len(input int n_words);
        return n_words + 3;
    endfunction

    localparam int PKT_LEN = pkt_len(N_WORDS_DEF);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SEQ,
        DATA,
        CSUM
    } tx_state_t;

endpackage

// File: rtl/telemetry_frame_reg.sv
// One snapshot of all channels plus its sequence number, with a valid flag.
// Used both as the pending slot and as the transmit bank.
module telemetry_frame_reg
    import telemetry_pkg::*;
#(
    parameter int N_WORDS = N_WORDS_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_i,
    input  logic                   clear_i,
    input  logic [32*N_WORDS-1:0]  words_i,
    input  logic [31:0]            seq_i,
    output logic [32*N_WORDS-1:0]  words_o,
    output logic [31:0]            seq_o,
    output logic                   valid_o
);

    logic [32*N_WORDS-1:0] words_q;
    logic [31:0]           seq_q;
    logic                  valid_q;

    // Load wins over clear so a slot freed and refilled in one cycle stays full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q <= '0;
            seq_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (load_i) begin
                words_q <= words_i;
                seq_q   <= seq_i;
            end
            if (load_i) begin
                valid_q <= 1'b1;
            end else if (clear_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign words_o = words_q;
    assign seq_o   = seq_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/telemetry_packetizer.sv
// Captures channel snapshots into a one-deep pending slot and streams each
// one out as a framed AXI4-Stream packet with a trailing XOR checksum.
//
// state | meaning
// IDLE  | no packet in flight; loads TX bank when the pending slot is full
// HDR   | presenting {MAGIC, N_WORDS}
// SEQ   | presenting the frame sequence number
// DATA  | presenting channel idx_q
// CSUM  | presenting XOR of all previous beats, tlast high
module telemetry_packetizer
    import telemetry_pkg::*;
#(
    parameter int N_WORDS = N_WORDS_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable_i,
    input  logic                   sample_valid_i,
    input  logic [32*N_WORDS-1:0]  samples_i,
    output logic [31:0]            m_tdata_o,
    output logic                   m_tvalid_o,
    input  logic                   m_tready_i,
    output logic                   m_tlast_o,
    output logic [15:0]            dropped_o,
    output logic                   busy_o
);

    localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);

    tx_state_t              state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [31:0]            csum_q, csum_d;
    logic [31:0]            seq_q;
    logic [15:0]            dropped_q;

    logic [32*N_WORDS-1:0]  slot_words, tx_words;
    logic [31:0]            slot_seq, tx_seq;
    logic                   slot_full, tx_valid_unused;

    logic capture, slot_load, drop, tx_load, beat_hs;

    assign capture   = sample_valid_i && enable_i;
    assign tx_load   = (state_q == IDLE) && slot_full;
    assign slot_load = capture && (!slot_full || tx_load);
    assign drop      = capture && !slot_load;
    assign beat_hs   = m_tvalid_o && m_tready_i;

    telemetry_frame_reg #(.N_WORDS(N_WORDS)) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (slot_load),
        .clear_i (tx_load),
        .words_i (samples_i),
        .seq_i   (seq_q),
        .words_o (slot_words),
        .seq_o   (slot_seq),
        .valid_o (slot_full)
    );

    // The TX bank is only read while state != IDLE, so its valid flag is unused.
    telemetry_frame_reg #(.N_WORDS(N_WORDS)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (tx_load),
        .clear_i (1'b0),
        .words_i (slot_words),
        .seq_i   (slot_seq),
        .words_o (tx_words),
        .seq_o   (tx_seq),
        .valid_o (tx_valid_unused)
    );

    // Sequence counts every enabled strobe, accepted or dropped; drop counter saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q     <= '0;
            dropped_q <= '0;
        end else begin
            if (capture) begin
                seq_q <= seq_q + 32'd1;
            end
            if (drop && (dropped_q != 16'hFFFF)) begin
                dropped_q <= dropped_q + 16'd1;
            end
        end
    end

    // Output beat mux: driven purely from registered state so it holds during stalls.
    always_comb begin
        m_tdata_o = '0;
        case (state_q)
            HDR:     m_tdata_o = {MAGIC, 16'(N_WORDS)};
            SEQ:     m_tdata_o = tx_seq;
            DATA:    m_tdata_o = tx_words[32*int'(idx_q) +: 32];
            CSUM:    m_tdata_o = csum_q;
            default: m_tdata_o = '0;
        endcase
    end

    assign m_tvalid_o = (state_q != IDLE);
    assign m_tlast_o  = (state_q == CSUM);
    assign dropped_o  = dropped_q;
    assign busy_o     = (state_q != IDLE) || slot_full;

    // TX sequencing and checksum accumulation over accepted beats.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        case (state_q)
            IDLE: begin
                if (tx_load) begin
                    state_d = HDR;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end
            HDR: begin
                if (beat_hs) begin
                    state_d = SEQ;
                    csum_d  = csum_q ^ m_tdata_o;
                end
            end
            SEQ: begin
                if (beat_hs) begin
                    state_d = DATA;
                    idx_d   = '0;
                    csum_d  = csum_q ^ m_tdata_o;
                end
            end
            DATA: begin
                if (beat_hs) begin
                    csum_d = csum_q ^ m_tdata_o;
                    if (idx_q == IDX_LAST) begin
                        state_d = CSUM;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            CSUM: begin
                if (beat_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // TX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
        end
    end

endmodule

// File: tb/tb_telemetry_packetizer.sv
// Directed + randomized bench for telemetry_packetizer with a transaction-level model.
module tb_telemetry_packetizer;

    localparam int N  = 24;
    localparam int PL = N + 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic            sample_valid = 1'b0;
    logic [32*N-1:0] samples = '0;
    logic [31:0]     tdata;
    logic            tvalid;
    logic            tready = 1'b0;
    logic            tlast;
    logic [15:0]     dropped;
    logic            busy;

    telemetry_packetizer #(.N_WORDS(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable),
        .sample_valid_i (sample_valid),
        .samples_i      (samples),
        .m_tdata_o      (tdata),
        .m_tvalid_o     (tvalid),
        .m_tready_i     (tready),
        .m_tlast_o      (tlast),
        .dropped_o      (dropped),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending frame, packet being sent, beats left to send.
    bit          m_slot_full;
    logic [31:0] m_slot_seq;
    logic [32*N-1:0] m_slot_data;
    logic [31:0] m_pkt [PL];
    int          m_left;
    logic [31:0] m_seq;
    int          m_drops;

    // Monitor bookkeeping.
    logic [32*N-1:0] samp;
    bit          prev_stall;
    logic [31:0] prev_tdata;
    int          pkts_done;
    int          seq_gaps;
    bit          seen_seq;
    logic [31:0] last_seq_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic build_pkt(input logic [31:0] seq, input logic [32*N-1:0] data);
        logic [31:0] x;
        m_pkt[0] = {16'hA5E1, 16'(N)};
        m_pkt[1] = seq;
        for (int k = 0; k < N; k++) m_pkt[2+k] = data[32*k +: 32];
        x = 0;
        for (int b = 0; b < PL - 1; b++) x = x ^ m_pkt[b];
        m_pkt[PL-1] = x;
    endtask

    task automatic model_reset();
        m_slot_full = 0;
        m_left = 0;
        m_seq = 0;
        m_drops = 0;
        prev_stall = 0;
        seen_seq = 0;
    endtask

    task automatic rand_samp();
        for (int k = 0; k < N; k++) samp[32*k +: 32] = $urandom;
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the model past the edge.
    task automatic step(input bit sv, input bit en, input bit rdy);
        int beat;
        bit idle;
        @(posedge clk);
        #1;
        sample_valid = sv;
        enable = en;
        tready = rdy;
        samples = samp;
        @(negedge clk);
        chk("tvalid", {31'b0, tvalid}, {31'b0, m_left > 0});
        chk("busy", {31'b0, busy}, {31'b0, (m_left > 0) || m_slot_full});
        chk("dropped", {16'b0, dropped}, 32'(m_drops));
        if (prev_stall) chk("stall_stable", tdata, prev_tdata);
        if (m_left > 0) begin
            beat = PL - m_left;
            chk($sformatf("beat%0d", beat), tdata, m_pkt[beat]);
            chk("tlast", {31'b0, tlast}, {31'b0, beat == PL - 1});
            if (rdy) begin
                if (beat == 1) begin
                    if (seen_seq && tdata != last_seq_seen + 1) seq_gaps++;
                    seen_seq = 1;
                    last_seq_seen = tdata;
                end
                if (beat == PL - 1) pkts_done++;
            end
        end
        prev_stall = tvalid && !rdy;
        prev_tdata = tdata;
        idle = (m_left == 0);
        if (idle && m_slot_full) begin
            build_pkt(m_slot_seq, m_slot_data);
            m_left = PL;
            m_slot_full = 0;
        end else if (!idle && rdy) begin
            m_left--;
        end
        if (sv && en) begin
            if (!m_slot_full) begin
                m_slot_full = 1;
                m_slot_seq = m_seq;
                m_slot_data = samp;
            end else if (m_drops < 65535) begin
                m_drops++;
            end
            m_seq = m_seq + 1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 0;
        sample_valid = 0;
        #1;
        chk("rst_tvalid", {31'b0, tvalid}, 0);
        chk("rst_tlast", {31'b0, tlast}, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_dropped", {16'b0, dropped}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    initial begin
        int p0, d0;
        model_reset();
        pkts_done = 0;
        seq_gaps = 0;
        samp = '0;

        // 1: single fixed frame, ready high, latency and exact words
        do_reset();
        for (int k = 0; k < N; k++) samp[32*k +: 32] = 32'h1000_0000 + k;
        step(1, 1, 1);
        step(0, 1, 1);
        chk("lat_t1_novalid", {31'b0, tvalid}, 0);
        step(0, 1, 1);
        chk("lat_t2_valid", {31'b0, tvalid}, 1);
        chk("first_hdr", tdata, 32'hA5E10018);
        step(0, 1, 1);
        chk("first_seq", tdata, 32'h0);
        step(0, 1, 1);
        chk("first_ch0", tdata, 32'h1000_0000);
        for (int i = 0; i < 30; i++) step(0, 1, 1);
        chk("t1_pkts", 32'(pkts_done), 1);

        // 2: random ready, random data
        rand_samp();
        p0 = pkts_done;
        step(1, 1, $urandom_range(0, 1));
        for (int i = 0; i < 140; i++) step(0, 1, $urandom_range(0, 1));
        for (int i = 0; i < 30; i++) step(0, 1, 1);
        chk("rand_pkt_done", 32'(pkts_done - p0), 1);

        // 3: strobes every 10 cycles, ready high: holds, drops, gaps
        do_reset();
        seq_gaps = 0;
        p0 = pkts_done;
        for (int f = 0; f < 12; f++) begin
            rand_samp();
            step(1, 1, 1);
            for (int i = 0; i < 9; i++) step(0, 1, 1);
        end
        for (int i = 0; i < 60; i++) step(0, 1, 1);
        chk("period_dropped", {16'b0, dropped}, 32'(m_drops));
        chk("period_some_drops", {31'b0, dropped != 0}, 1);
        chk("period_gaps", {31'b0, seq_gaps > 0}, 1);
        chk("period_pkts", 32'(pkts_done - p0), 32'(12 - m_drops));

        // 4: strobe in the IDLE->HDR load cycle is captured
        do_reset();
        p0 = pkts_done;
        rand_samp();
        step(1, 1, 1);
        rand_samp();
        step(1, 1, 1);
        step(0, 1, 1);
        chk("load_cycle_nodrop", {16'b0, dropped}, 0);
        for (int i = 0; i < 60; i++) step(0, 1, 1);
        chk("load_cycle_pkts", 32'(pkts_done - p0), 2);

        // 5: enable low blocks capture and sequence
        do_reset();
        for (int s = 0; s < 3; s++) begin
            rand_samp();
            step(1, 0, 1);
            step(0, 0, 1);
            step(0, 0, 1);
        end
        chk("en_low_idle", {31'b0, busy}, 0);
        rand_samp();
        seen_seq = 0;
        step(1, 1, 1);
        for (int i = 0; i < 32; i++) step(0, 1, 1);
        chk("en_seq0", last_seq_seen, 0);

        // 6: reset mid-DATA after a drop
        do_reset();
        rand_samp();
        step(1, 1, 1);
        step(0, 1, 1);
        step(1, 1, 1);
        step(1, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 1);
        chk("pre_rst_drop", {16'b0, dropped}, 1);
        do_reset();
        rand_samp();
        seen_seq = 0;
        p0 = pkts_done;
        step(1, 1, 1);
        for (int i = 0; i < 32; i++) step(0, 1, 1);
        chk("post_rst_seq0", last_seq_seen, 0);
        chk("post_rst_pkt", 32'(pkts_done - p0), 1);

        // 7: drop counter saturation with ready held low
        do_reset();
        rand_samp();
        step(1, 1, 0);
        step(1, 1, 0);
        for (int i = 0; i < 65540; i++) step(1, 1, 0);
        chk("sat_ffff", {16'b0, dropped}, 32'h0000_FFFF);
        step(1, 1, 0);
        chk("sat_hold", {16'b0, dropped}, 32'h0000_FFFF);
        d0 = m_drops;
        chk("sat_model", 32'(d0), 32'd65535);
        for (int i = 0; i < 70; i++) step(0, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
